// File: rtl/pipe_stage_hs_pkg.sv
// Shared definitions for the pipelined-CPU inter-stage registers:
// control-word bit positions and default widths.
package pipe_pkg;

    // Bit positions inside the stage control word
    localparam int CTRL_MEMTOREG = 0;
    localparam int CTRL_REGWRE   = 1;

    // Default widths
    localparam int DEF_DATA_W = 106;
    localparam int DEF_CTRL_W = 3;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/pipe_stage_hs_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clears on rst.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    // Count up until all ones, then hold
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
            count_reg <= count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_stage_hs.sv
// Inter-stage pipeline register with valid/ready handshake, stall, flush,
// optional second (skid) entry and saturating stall/bubble counters.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              head_valid_reg, head_valid_next;
    logic [CTRL_W-1:0] head_ctrl_reg,  head_ctrl_next;
    logic [DATA_W-1:0] head_data_reg,  head_data_next;

    logic              skid_valid_reg;
    logic [CTRL_W-1:0] skid_ctrl_reg;
    logic [DATA_W-1:0] skid_data_reg;

    logic accept;
    logic emit;

    assign accept = in_valid && in_ready;
    assign emit   = head_valid_reg && out_ready && !stall;

    // Head next-state: flush clears, stall holds, emit refills from skid/input or empties
    always_comb begin
        head_valid_next = head_valid_reg;
        head_ctrl_next  = head_ctrl_reg;
        head_data_next  = head_data_reg;
        if (flush) begin
            head_valid_next = 1'b0;
            head_ctrl_next  = '0;
            head_data_next  = '0;
        end else if (!stall) begin
            if (emit) begin
                if (skid_valid_reg) begin
                    head_valid_next = 1'b1;
                    head_ctrl_next  = skid_ctrl_reg;
                    head_data_next  = skid_data_reg;
                end else if (accept) begin
                    head_valid_next = 1'b1;
                    head_ctrl_next  = in_ctrl;
                    head_data_next  = in_data;
                end else begin
                    // Data is left as-is; only valid and ctrl drop
                    head_valid_next = 1'b0;
                    head_ctrl_next  = '0;
                end
            end else if (!head_valid_reg && accept) begin
                head_valid_next = 1'b1;
                head_ctrl_next  = in_ctrl;
                head_data_next  = in_data;
            end
        end
    end

    // Head register
    always_ff @(posedge clk) begin
        if (rst) begin
            head_valid_reg <= 1'b0;
            head_ctrl_reg  <= '0;
            head_data_reg  <= '0;
        end else begin
            head_valid_reg <= head_valid_next;
            head_ctrl_reg  <= head_ctrl_next;
            head_data_reg  <= head_data_next;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            // in_ready depends only on registered skid occupancy and the global controls
            assign in_ready = !skid_valid_reg && !stall && !flush && !rst;

            // Skid entry: parks an input accepted while the head is blocked
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    skid_valid_reg <= 1'b0;
                    skid_ctrl_reg  <= '0;
                    skid_data_reg  <= '0;
                end else if (!stall) begin
                    if (emit && skid_valid_reg) begin
                        skid_valid_reg <= 1'b0;
                        skid_ctrl_reg  <= '0;
                    end else if (accept && head_valid_reg && !emit) begin
                        skid_valid_reg <= 1'b1;
                        skid_ctrl_reg  <= in_ctrl;
                        skid_data_reg  <= in_data;
                    end
                end
            end
        end else begin : g_noskid
            // Single entry: accept when empty or draining this cycle
            assign in_ready       = (!head_valid_reg || out_ready) && !stall && !flush && !rst;
            assign skid_valid_reg = 1'b0;
            assign skid_ctrl_reg  = '0;
            assign skid_data_reg  = '0;
        end
    endgenerate

    assign out_valid = head_valid_reg;
    assign out_data  = head_data_reg;
    // Gate ctrl so no write-enable can leak out of an empty stage
    assign out_ctrl  = head_valid_reg ? head_ctrl_reg : '0;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!head_valid_reg),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Self-checking bench for pipe_stage_hs (SKID=1, narrow counters so
// saturation is reachable). A queue-based occupancy model predicts every
// output each cycle; directed phases precede a randomized run.
module tb_pipe_stage_hs;

    localparam int DW  = 106;
    localparam int CW  = 3;
    localparam int NW  = 4;
    localparam int SAT = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          rst, stall, flush, in_valid, out_ready;
    logic          in_ready, out_valid;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [NW-1:0] stall_cnt, bubble_cnt;

    always #5 clk = ~clk;

    pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    // Reference model: FIFO of entries held in the stage (capacity 2)
    ent_t          q[$];
    ent_t          e_new;
    ent_t          e_pop;
    logic [DW-1:0] last_d  = '0;
    int            stall_m = 0;
    int            bub_m   = 0;
    int            n_cmp   = 0;
    int            n_bad   = 0;
    bit            armed   = 1'b0;
    bit            rdy_m;
    bit            acc_m;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // State is only defined once reset has been sampled
    always @(posedge clk) if (rst) armed <= 1'b1;

    // Monitor: compare outputs against the model, then advance the model to the next edge
    always @(negedge clk) begin
        if (armed) begin
            rdy_m = (q.size() < 2) && !stall && !flush && !rst;
            chk("in_ready",   128'(in_ready),   128'(rdy_m));
            chk("out_valid",  128'(out_valid),  128'(q.size() > 0));
            chk("out_ctrl",   128'(out_ctrl),   (q.size() > 0) ? 128'(q[0].c) : 128'd0);
            chk("out_data",   128'(out_data),   (q.size() > 0) ? 128'(q[0].d) : 128'(last_d));
            chk("stall_cnt",  128'(stall_cnt),  128'(stall_m));
            chk("bubble_cnt", 128'(bubble_cnt), 128'(bub_m));

            if (rst) begin
                q.delete();
                last_d  = '0;
                stall_m = 0;
                bub_m   = 0;
            end else begin
                if (q.size() == 0 && bub_m < SAT) bub_m++;
                if (stall && stall_m < SAT) stall_m++;
                if (flush) begin
                    q.delete();
                    last_d = '0;
                end else if (!stall) begin
                    acc_m = in_valid && rdy_m;
                    if (q.size() > 0 && out_ready) begin
                        e_pop  = q.pop_front();
                        last_d = e_pop.d;
                        $display("emit data=%h ctrl=%b", e_pop.d, e_pop.c);
                    end
                    if (acc_m) begin
                        e_new.d = in_data;
                        e_new.c = in_ctrl;
                        q.push_back(e_new);
                    end
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input bit ordy, input bit st, input bit fl, input bit r);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    logic [127:0] rnd;

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; in_data = '0; in_ctrl = '0;
        #1;
        // Reset for two cycles
        drive(0, '0, '0, 0, 0, 0, 1);
        drive(0, '0, '0, 0, 0, 0, 1);
        // Streaming with downstream always ready
        drive(1, DW'(32'h11), 3'd1, 1, 0, 0, 0);
        drive(1, DW'(32'h22), 3'd2, 1, 0, 0, 0);
        drive(1, DW'(32'h33), 3'd3, 1, 0, 0, 0);
        drive(0, '0, '0, 1, 0, 0, 0);
        drive(0, '0, '0, 1, 0, 0, 0);
        // Skid fill with downstream blocked, then drain
        drive(1, DW'(32'hA), 3'd2, 0, 0, 0, 0);
        drive(1, DW'(32'hB), 3'd3, 0, 0, 0, 0);
        drive(1, DW'(32'hC), 3'd4, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, '0, '0, 1, 0, 0, 0);
        // Stall holding head 0x5 / ctrl 101 for three cycles
        drive(1, DW'(32'h5), 3'b101, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, DW'(32'h77), 3'd1, 1, 1, 0, 0);
        drive(0, '0, '0, 1, 0, 0, 0);
        // Flush with head and skid full and input valid
        drive(1, DW'(32'h1), 3'd1, 0, 0, 0, 0);
        drive(1, DW'(32'h2), 3'd2, 0, 0, 0, 0);
        drive(1, DW'(32'h3), 3'd3, 0, 0, 1, 0);
        // Flush together with stall
        drive(1, DW'(32'h4), 3'd4, 0, 0, 0, 0);
        drive(1, DW'(32'h5), 3'd5, 0, 0, 0, 0);
        drive(1, DW'(32'h6), 3'd6, 1, 1, 1, 0);
        // Long idle: bubble counter must saturate
        for (int i = 0; i < 20; i++) drive(0, '0, '0, 1, 0, 0, 0);
        // Randomized traffic, including occasional reset mid-transfer
        for (int i = 0; i < 600; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            drive(1'($urandom % 2), rnd[DW-1:0], 3'($urandom),
                  1'(($urandom % 4) != 0), 1'(($urandom % 8) == 0),
                  1'(($urandom % 16) == 0), 1'(($urandom % 64) == 0));
        end
        for (int i = 0; i < 4; i++) drive(0, '0, '0, 1, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
